// File: rtl/hazard_detect_unit.sv
// Pipeline hazard detection: same-cycle freeze/bubble/flush decision, plus
// a small state machine, stall/flush statistics and a sticky stall watchdog.
module hazard_detect_unit #(
  parameter int unsigned WD_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fwd_en,
  input  logic        id_valid,
  input  logic [4:0]  id_src1,
  input  logic [4:0]  id_src2,
  input  logic        id_is_imm,
  input  logic [1:0]  id_br_type,
  input  logic [4:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [4:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        br_taken,
  output logic        freeze,
  output logic        bubble,
  output logic        flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        wd_err
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned RUN_W = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0]       BR_BNE  = 2'b10;
  localparam logic [1:0]       BR_JMP  = 2'b11;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // run_len value seen on the edge that completes the WD_LIMIT-th stall
  localparam logic [RUN_W-1:0] WD_TRIP = RUN_W'(WD_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [RUN_W-1:0] run_len;
  logic             uses1;
  logic             uses2;
  logic             exe_match;
  logic             mem_match;
  logic             hz;
  logic             stall_now;

  // Producer/consumer match; register 0 is hard-wired and never a hazard
  function automatic logic reg_match(
    input logic [REG_W-1:0] dest,
    input logic             en,
    input logic [REG_W-1:0] src1,
    input logic [REG_W-1:0] src2,
    input logic             use1,
    input logic             use2
  );
    logic hit;
    hit = (use1 && (src1 == dest)) || (use2 && (src2 == dest));
    return en && (dest != '0) && hit;
  endfunction

  // Operand usage decode and hazard evaluation
  always_comb begin
    uses1     = (id_br_type != BR_JMP);
    uses2     = !id_is_imm || (id_br_type == BR_BNE);
    exe_match = reg_match(exe_dest, exe_wb_en, id_src1, id_src2, uses1, uses2);
    mem_match = reg_match(mem_dest, mem_wb_en, id_src1, id_src2, uses1, uses2);
    if (fwd_en) begin
      // With forwarding only a load in EXE cannot be bypassed in time
      hz = id_valid && exe_match && exe_mem_r_en;
    end else begin
      hz = id_valid && (exe_match || mem_match);
    end
    stall_now = hz && !br_taken;
  end

  // Next-state and same-cycle pipeline control; a taken branch wins
  always_comb begin
    state_d = ST_RUN;
    freeze  = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    if (br_taken) begin
      flush   = 1'b1;
      bubble  = 1'b1;
      state_d = ST_FLUSH;
    end else if (hz) begin
      freeze  = 1'b1;
      bubble  = 1'b1;
      state_d = ST_STALL;
    end
    // The unused encoding follows the same rule and so always leaves
    case (state_q)
      ST_RUN, ST_STALL, ST_FLUSH: ;
      default: if (!br_taken && !hz) state_d = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // Consecutive stall length and sticky watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      run_len <= '0;
      wd_err  <= 1'b0;
    end else begin
      if (state_d == ST_STALL) begin
        run_len <= (run_len == RUN_MAX) ? run_len : run_len + RUN_W'(1);
      end else begin
        run_len <= '0;
      end
      if (stall_now && (run_len == WD_TRIP)) begin
        wd_err <= 1'b1;
      end
    end
  end

  // Saturating stall and flush statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_now && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (br_taken && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_hazard_detect_unit;

  localparam int WD = 3;

  logic        clk = 1'b0;
  logic        rst, fwd_en, id_valid, id_is_imm, exe_wb_en, exe_mem_r_en;
  logic        mem_wb_en, br_taken;
  logic [4:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic [1:0]  id_br_type;
  logic        freeze, bubble, flush, wd_err;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // model state: plain integers following the written rules
  int m_state, m_run, m_stall, m_flush, m_wd;

  hazard_detect_unit #(.WD_LIMIT(WD)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_is_imm(id_is_imm),
    .id_br_type(id_br_type), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .br_taken(br_taken), .freeze(freeze), .bubble(bubble), .flush(flush),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  function automatic int reads(input int d, input int en);
    int u1, u2;
    u1 = (id_br_type != 2'b11);
    u2 = (id_is_imm == 1'b0) || (id_br_type == 2'b10);
    return (en != 0 && d != 0 && ((u1 != 0 && int'(id_src1) == d) ||
            (u2 != 0 && int'(id_src2) == d))) ? 1 : 0;
  endfunction

  function automatic int model_hz();
    int e, m;
    e = reads(int'(exe_dest), int'(exe_wb_en));
    m = reads(int'(mem_dest), int'(mem_wb_en));
    if (!id_valid) return 0;
    if (fwd_en) return (e != 0 && exe_mem_r_en) ? 1 : 0;
    return (e != 0 || m != 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int h, ef, eb, el;
    h  = model_hz();
    el = br_taken ? 1 : 0;
    eb = (br_taken || h != 0) ? 1 : 0;
    ef = (!br_taken && h != 0) ? 1 : 0;
    chk("freeze", int'(freeze), ef);
    chk("bubble", int'(bubble), eb);
    chk("flush", int'(flush), el);
    chk("state", int'(state), m_state);
    chk("stall_cnt", int'(stall_cnt), m_stall);
    chk("flush_cnt", int'(flush_cnt), m_flush);
    chk("wd_err", int'(wd_err), m_wd);
  endtask

  task automatic model_edge();
    int h;
    h = model_hz();
    if (rst) begin
      m_state = 0; m_run = 0; m_stall = 0; m_flush = 0; m_wd = 0;
    end else if (br_taken) begin
      m_state = 2; m_run = 0;
      if (m_flush < 65535) m_flush++;
    end else if (h != 0) begin
      m_state = 1;
      if (m_run == WD - 1) m_wd = 1;
      if (m_run < 7) m_run++;
      if (m_stall < 65535) m_stall++;
    end else begin
      m_state = 0; m_run = 0;
    end
  endtask

  // compare at negedge, advance model and DUT together, then release inputs
  task automatic cycle(input int do_cmp);
    @(negedge clk);
    if (do_cmp != 0) compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; fwd_en = 1; id_valid = 1; id_src1 = 0; id_src2 = 0; id_is_imm = 0;
    id_br_type = 0; exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0; br_taken = 0;
  endtask

  task automatic load_use();
    idle();
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; id_src1 = 5;
  endtask

  task automatic do_reset();
    idle(); rst = 1;
    cycle(1); cycle(1);
    rst = 0;
  endtask

  initial begin
    m_state = 0; m_run = 0; m_stall = 0; m_flush = 0; m_wd = 0;
    idle(); rst = 1;
    @(posedge clk); model_edge(); #1;
    cycle(1);
    rst = 0;
    // reset values
    chk("rst_state", int'(state), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_wd_err", int'(wd_err), 0);

    // load-use with forwarding
    load_use(); #1;
    chk("lu_freeze", int'(freeze), 1);
    chk("lu_bubble", int'(bubble), 1);
    cycle(1);
    chk("lu_state", int'(state), 1);
    chk("lu_stall_cnt", int'(stall_cnt), 1);

    // ALU result is forwarded; without forwarding it stalls
    exe_mem_r_en = 0; #1;
    chk("alu_fwd_freeze", int'(freeze), 0);
    cycle(1);
    chk("alu_fwd_state", int'(state), 0);
    fwd_en = 0; #1;
    chk("nofwd_freeze", int'(freeze), 1);
    cycle(1);
    chk("nofwd_stall_cnt", int'(stall_cnt), 2);

    // immediate operand and register 0
    idle(); exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 7; id_src2 = 7;
    id_src1 = 3; id_is_imm = 1; #1;
    chk("imm_freeze", int'(freeze), 0);
    cycle(1);
    idle(); exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 0; id_src1 = 0; #1;
    chk("r0_freeze", int'(freeze), 0);
    cycle(1);
    // BNE reads src2 even when flagged immediate
    idle(); exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 7; id_src2 = 7;
    id_is_imm = 1; id_br_type = 2'b10; #1;
    chk("bne_freeze", int'(freeze), 1);
    cycle(1);

    // branch priority over a hazard
    load_use(); br_taken = 1; #1;
    chk("br_flush", int'(flush), 1);
    chk("br_bubble", int'(bubble), 1);
    chk("br_freeze", int'(freeze), 0);
    cycle(1);
    chk("br_state", int'(state), 2);
    chk("br_flush_cnt", int'(flush_cnt), 1);
    chk("br_stall_cnt", int'(stall_cnt), 3);

    // invalid ID suppresses hazard, not flush
    load_use(); id_valid = 0; #1;
    chk("inval_freeze", int'(freeze), 0);
    br_taken = 1; #1;
    chk("inval_flush", int'(flush), 1);
    cycle(1);

    // combinational outputs still act during reset
    idle(); rst = 1; br_taken = 1; #1;
    chk("rst_br_flush", int'(flush), 1);
    cycle(1);

    // watchdog trips on the third consecutive stall and sticks
    do_reset();
    load_use();
    cycle(1); chk("wd_after1", int'(wd_err), 0);
    cycle(1); chk("wd_after2", int'(wd_err), 0);
    cycle(1); chk("wd_after3", int'(wd_err), 1);
    idle(); cycle(1); chk("wd_held", int'(wd_err), 1);
    rst = 1; cycle(1); rst = 0;
    chk("wd_cleared", int'(wd_err), 0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      fwd_en       = 1'($urandom);
      id_valid     = ($urandom_range(0, 7) != 0);
      id_src1      = 5'($urandom_range(0, 3));
      id_src2      = 5'($urandom_range(0, 3));
      id_is_imm    = 1'($urandom);
      id_br_type   = 2'($urandom);
      exe_dest     = 5'($urandom_range(0, 3));
      exe_wb_en    = ($urandom_range(0, 3) != 0);
      exe_mem_r_en = 1'($urandom);
      mem_dest     = 5'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom);
      br_taken     = ($urandom_range(0, 7) == 0);
      cycle(1);
    end

    // stall counter saturation
    do_reset();
    load_use();
    for (int i = 0; i < 65536; i++) cycle(0);
    chk("sat_stall_cnt", int'(stall_cnt), 65535);
    cycle(1);
    chk("sat_no_wrap", int'(stall_cnt), 65535);
    idle(); cycle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
